// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq
// Multicycle instruction fetch sequencer. It fetches one 32-bit instruction
// as two 16-bit halfwords, upper half first, using a req/ack handshake on the
// memory bus. The instruction register is told which half to capture via
// IRWr1 (upper) and IRWr0 (lower). This block owns the PC.
//
// Ports
//   Fclk, reset       clock; synchronous active-high reset
//   fetch_start       request next instruction (honoured in IDLE only)
//   pc_load,
//   pc_next_in        redirect; honoured in IDLE and DONE, bit 0 forced to 0
//   mem_ack           memory data valid for current mem_addr
//   mem_req, mem_addr read request and halfword byte address
//   IRWr1, IRWr0      one-cycle IR half write enables (Mealy on mem_ack)
//   MemWrite          tied 0; this block only reads
//   pc                address of the instruction held or being fetched
//   instr_valid       one-cycle pulse after both halves are written
//   busy              high outside IDLE
//   fetch_fault       ack timeout seen; held until reset
module instr_fetch_seq #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                TIMEOUT  = 15
) (
   input  logic              Fclk,
   input  logic              reset,
   input  logic              fetch_start,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_next_in,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              IRWr1,
   output logic              IRWr0,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] pc,
   output logic              instr_valid,
   output logic              busy,
   output logic              fetch_fault
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, REQ_HI, REQ_LO, DONE, FAULT} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic [CNT_W-1:0]  wait_cnt, wait_nxt;
   logic [ADDR_W-1:0] redirect;
   logic              pc_bit0_unused;

   // Instructions are halfword aligned; the low bit of a redirect is dropped.
   assign redirect       = {pc_next_in[ADDR_W-1:1], 1'b0};
   assign pc_bit0_unused = pc_next_in[0];

   always_ff @(posedge Fclk) begin
      if (reset) begin
         state    <= IDLE;
         pc_q     <= RESET_PC;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         pc_q     <= pc_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc_q;
      wait_nxt    = '0;   // zero unless we stay waiting, so every state entry starts at 0
      mem_req     = 1'b0;
      mem_addr    = pc_q;
      IRWr1       = 1'b0;
      IRWr0       = 1'b0;
      instr_valid = 1'b0;
      case (state)
         IDLE: begin
            // A redirect and a start in the same cycle: the fetch uses the new PC,
            // which is registered before REQ_HI drives mem_addr.
            if (pc_load)     pc_nxt    = redirect;
            if (fetch_start) state_nxt = REQ_HI;
         end
         REQ_HI: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               IRWr1     = ~reset;   // reset wins over an ack in the same cycle
               state_nxt = REQ_LO;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               state_nxt = FAULT;
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         REQ_LO: begin
            mem_req  = 1'b1;
            mem_addr = pc_q + ADDR_W'(2);
            if (mem_ack) begin
               IRWr0     = ~reset;
               state_nxt = DONE;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               state_nxt = FAULT;
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         DONE: begin
            instr_valid = ~reset;
            pc_nxt      = pc_load ? redirect : pc_q + ADDR_W'(4);
            state_nxt   = IDLE;
         end
         FAULT: ;   // parked until reset
         default: state_nxt = IDLE;
      endcase
   end

   assign pc          = pc_q;
   assign busy        = (state != IDLE);
   assign fetch_fault = (state == FAULT);
   assign MemWrite    = 1'b0;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: a per-cycle vector table for zero-wait
// fetches, redirects and PC wrap, then hand sequences for wait states,
// ack timeout and reset during a fetch.
module tb_instr_fetch_seq;

   logic        Fclk = 1'b0;
   logic        reset, fetch_start, pc_load, mem_ack;
   logic [15:0] pc_next_in;
   logic        mem_req, IRWr1, IRWr0, MemWrite, instr_valid, busy, fetch_fault;
   logic [15:0] mem_addr, pc;

   int errors = 0;
   int checks = 0;

   instr_fetch_seq #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
      .Fclk(Fclk), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
      .pc_next_in(pc_next_in), .mem_ack(mem_ack), .mem_req(mem_req),
      .mem_addr(mem_addr), .IRWr1(IRWr1), .IRWr0(IRWr0), .MemWrite(MemWrite),
      .pc(pc), .instr_valid(instr_valid), .busy(busy), .fetch_fault(fetch_fault)
   );

   always #5 Fclk = ~Fclk;

   typedef struct packed {
      logic        req;
      logic [15:0] addr;
      logic        w1, w0, iv;
      logic [15:0] pc;
      logic        busy, fault, mw;
   } out_t;

   typedef struct packed {
      logic        rst, fs, pl;
      logic [15:0] pni;
      logic        ack;
      out_t        exp;
   } vec_t;

   localparam out_t RST_OUT = '{req:1'b0, addr:16'h0, w1:1'b0, w0:1'b0, iv:1'b0,
                                pc:16'h0, busy:1'b0, fault:1'b0, mw:1'b0};

   function automatic out_t cur();
      out_t o;
      o = '{req:mem_req, addr:mem_addr, w1:IRWr1, w0:IRWr0, iv:instr_valid,
            pc:pc, busy:busy, fault:fetch_fault, mw:MemWrite};
      return o;
   endfunction

   function automatic vec_t v(logic rst, logic fs, logic pl, logic [15:0] pni, logic ack,
                              logic req, logic [15:0] addr, logic w1, logic w0,
                              logic iv, logic [15:0] p, logic bsy);
      vec_t r;
      r.rst = rst; r.fs = fs; r.pl = pl; r.pni = pni; r.ack = ack;
      r.exp = '{req:req, addr:addr, w1:w1, w0:w0, iv:iv, pc:p, busy:bsy,
                fault:1'b0, mw:1'b0};
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on
   // the falling edge, which sees the Mealy IRWr outputs for this cycle.
   task automatic drive(input logic rst, input logic fs, input logic pl,
                        input logic [15:0] pni, input logic ack);
      reset = rst; fetch_start = fs; pc_load = pl; pc_next_in = pni; mem_ack = ack;
      @(negedge Fclk);
   endtask

   task automatic next_cycle();
      @(posedge Fclk);
      #1;
   endtask

   vec_t tbl[23];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_busy, iv_c, w1_cnt, w0_cnt;
      out_t o;

      //        rst fs pl pni      ack  req addr     w1 w0 iv pc       busy
      tbl[0]  = v(0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 16'h0000, 0); // reset state
      tbl[1]  = v(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 16'h0000, 0); // start
      tbl[2]  = v(0, 0, 0, 16'h0000, 1,  1, 16'h0000, 1, 0, 0, 16'h0000, 1); // hi, 2008
      tbl[3]  = v(0, 0, 0, 16'h0000, 1,  1, 16'h0002, 0, 1, 0, 16'h0000, 1); // lo, 0005
      tbl[4]  = v(0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 1, 16'h0000, 1); // done
      tbl[5]  = v(0, 0, 0, 16'h0000, 0,  0, 16'h0004, 0, 0, 0, 16'h0004, 0); // pc=4
      tbl[6]  = v(0, 1, 1, 16'h0101, 0,  0, 16'h0004, 0, 0, 0, 16'h0004, 0); // load+start
      tbl[7]  = v(0, 0, 0, 16'h0000, 1,  1, 16'h0100, 1, 0, 0, 16'h0100, 1);
      tbl[8]  = v(0, 0, 1, 16'h2000, 1,  1, 16'h0102, 0, 1, 0, 16'h0100, 1); // load ignored
      tbl[9]  = v(0, 0, 0, 16'h0000, 0,  0, 16'h0100, 0, 0, 1, 16'h0100, 1);
      tbl[10] = v(0, 0, 0, 16'h0000, 0,  0, 16'h0104, 0, 0, 0, 16'h0104, 0);
      tbl[11] = v(0, 1, 1, 16'hFFFC, 0,  0, 16'h0104, 0, 0, 0, 16'h0104, 0);
      tbl[12] = v(0, 0, 0, 16'h0000, 1,  1, 16'hFFFC, 1, 0, 0, 16'hFFFC, 1);
      tbl[13] = v(0, 0, 0, 16'h0000, 1,  1, 16'hFFFE, 0, 1, 0, 16'hFFFC, 1);
      tbl[14] = v(0, 0, 0, 16'h0000, 0,  0, 16'hFFFC, 0, 0, 1, 16'hFFFC, 1);
      tbl[15] = v(0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 16'h0000, 0); // pc wraps
      tbl[16] = v(0, 1, 1, 16'hFFFF, 0,  0, 16'h0000, 0, 0, 0, 16'h0000, 0); // bit0 dropped
      tbl[17] = v(0, 0, 0, 16'h0000, 1,  1, 16'hFFFE, 1, 0, 0, 16'hFFFE, 1);
      tbl[18] = v(0, 0, 0, 16'h0000, 1,  1, 16'h0000, 0, 1, 0, 16'hFFFE, 1); // pc+2 wraps
      tbl[19] = v(0, 0, 1, 16'h0040, 0,  0, 16'hFFFE, 0, 0, 1, 16'hFFFE, 1); // redirect in DONE
      tbl[20] = v(0, 0, 0, 16'h0000, 0,  0, 16'h0040, 0, 0, 0, 16'h0040, 0);
      tbl[21] = v(0, 0, 0, 16'h0000, 1,  0, 16'h0040, 0, 0, 0, 16'h0040, 0); // stray ack
      tbl[22] = v(0, 0, 0, 16'h0000, 0,  0, 16'h0040, 0, 0, 0, 16'h0040, 0);

      reset = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_next_in = '0; mem_ack = 1'b0;
      next_cycle();
      next_cycle();

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].rst, tbl[i].fs, tbl[i].pl, tbl[i].pni, tbl[i].ack);
         chk($sformatf("vec%0d", i), 64'(cur()), 64'(tbl[i].exp));
         next_cycle();
      end

      // Three wait cycles per halfword from pc=0040: acks land in cycles 4 and 8.
      drive(0, 1, 0, 16'h0, 0);
      next_cycle();
      first_busy = -1; iv_c = -1; w1_cnt = 0; w0_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         drive(0, 0, 0, 16'h0, (c == 4 || c == 8));
         if (busy && first_busy < 0) first_busy = c;
         if (IRWr1) w1_cnt++;
         if (IRWr0) w0_cnt++;
         if (instr_valid) iv_c = c;
         if (c <= 8)
            chk($sformatf("wait c%0d req/addr/w1/w0", c),
                64'({mem_req, mem_addr, IRWr1, IRWr0}),
                64'({1'b1, (c <= 4) ? 16'h0040 : 16'h0042, (c == 4), (c == 8)}));
         next_cycle();
      end
      chk("wait irwr1 count", 64'(w1_cnt), 64'd1);
      chk("wait irwr0 count", 64'(w0_cnt), 64'd1);
      chk("wait valid latency", 64'(iv_c - first_busy), 64'd8);
      chk("wait pc/fault", 64'({pc, fetch_fault}), 64'({16'h0044, 1'b0}));

      // Timeout: 15 cycles in REQ_HI without ack, then FAULT.
      drive(0, 1, 0, 16'h0, 0);
      next_cycle();
      for (int k = 1; k <= 15; k++) begin
         drive(0, 0, 0, 16'h0, 0);
         chk($sformatf("timeout k%0d req/fault", k), 64'({mem_req, fetch_fault}), 64'({1'b1, 1'b0}));
         next_cycle();
      end
      drive(0, 0, 0, 16'h0, 0);
      chk("fault entered", 64'({mem_req, fetch_fault, busy}), 64'({1'b0, 1'b1, 1'b1}));
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 16'h0, 1);
         chk($sformatf("fault hold %0d", k), 64'({mem_req, IRWr1, IRWr0, fetch_fault}),
             64'({1'b0, 1'b0, 1'b0, 1'b1}));
         next_cycle();
      end
      drive(1, 0, 0, 16'h0, 0);
      next_cycle();
      drive(0, 0, 0, 16'h0, 0);
      chk("fault cleared by reset", 64'(cur()), 64'(RST_OUT));
      next_cycle();

      // Reset during REQ_LO with an ack present: no IRWr0, reset values next cycle.
      drive(0, 1, 1, 16'h1230, 0);
      next_cycle();
      drive(0, 0, 0, 16'h0, 1);
      chk("hi at 1230", 64'({IRWr1, mem_addr}), 64'({1'b1, 16'h1230}));
      next_cycle();
      drive(1, 0, 0, 16'h0, 1);
      chk("reset blocks irwr0", 64'({mem_addr, IRWr0, IRWr1}), 64'({16'h1232, 1'b0, 1'b0}));
      next_cycle();
      drive(0, 0, 0, 16'h0, 0);
      o = cur();
      chk("after mid-fetch reset", 64'(o), 64'(RST_OUT));
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Multicycle fetch sequencer directly upstream of the instruction/data register stage.
- Fetches one 32-bit MIPS instruction as two 16-bit halfwords over the 16-bit memory data bus. Issues PC-addressed memory reads with a req/ack handshake.
- Pulses IRWr1 for the upper halfword and IRWr0 for the lower halfword, so the instruction register captures data_in on the correct half.
- Signals instr_valid to the control FSM, owns the PC, and advances or redirects it.

Parameters:
- ADDR_W, 16, width of PC and memory byte address.
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT, 15, maximum wait cycles for mem_ack before a fault.

Ports:
- Fclk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_start  in  1  control FSM requests the next instruction; sampled in IDLE only.
- pc_load  in  1  redirect: load pc_next_in into PC (branch/jump).
- pc_next_in  in  ADDR_W  redirect target; bit 0 is ignored (forced 0).
- mem_ack  in  1  memory has data_in valid this cycle for the current mem_addr.
- mem_req  out  1  read request to memory.
- mem_addr  out  ADDR_W  byte address of the current halfword read.
- IRWr1  out  1  one-cycle write enable, upper instruction half (out[31:16]).
- IRWr0  out  1  one-cycle write enable, lower instruction half (out[15:0]).
- MemWrite  out  1  held 0 by this block during fetch; io mux selects the read path.
- pc  out  ADDR_W  address of the instruction currently held or being fetched.
- instr_valid  out  1  one-cycle pulse: both halves have been written.
- busy  out  1  high in any state other than IDLE.
- fetch_fault  out  1  sticky: mem_ack timed out; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, IRWr0=IRWr1=0, instr_valid=0, busy=0, fetch_fault=0, wait counter=0. Reset overrides every other input in the same cycle, including mid-fetch; no IRWr pulse is issued on a reset cycle.
- States: IDLE, REQ_HI, REQ_LO, DONE, FAULT.
- IDLE:
  - pc_load=1 → pc <= {pc_next_in[ADDR_W-1:1],0}.
  - Otherwise, fetch_start=1 → REQ_HI.
  - If both are high in the same cycle, pc_load applies first and the fetch starts from the new PC.
- REQ_HI:
  - mem_req=1, mem_addr=pc.
  - On mem_ack: IRWr1=1 for exactly that cycle, then go to REQ_LO.
  - Without ack: increment the wait counter.
- REQ_LO:
  - mem_req=1, mem_addr=pc+2 (modulo 2^ADDR_W; wraps from 16'hFFFE to 16'h0000).
  - On mem_ack: IRWr0=1 for that cycle, then go to DONE.
- Wait counter: cleared on each state entry. If it reaches TIMEOUT without an ack, go to FAULT.
- DONE:
  - instr_valid=1 for one cycle; pc <= pc+4 (wraps).
  - If pc_load=1 in DONE, pc <= the redirect target instead of pc+4.
  - Next state: IDLE.
- FAULT: mem_req=0, fetch_fault=1. The state holds until reset; fetch_start is ignored.
- pc_load during REQ_HI/REQ_LO is ignored; the fetch in progress completes at the old pc.
- mem_ack outside REQ_HI/REQ_LO is ignored and produces no IRWr pulse.
- Minimum latency with zero-wait memory (ack in the same cycle as req), from the fetch_start edge:
  - IRWr1 at cycle 1.
  - IRWr0 at cycle 2.
  - instr_valid at cycle 3.
  - fetch_start accepted again at cycle 4.
- IRWr0 and IRWr1 are never high in the same cycle. MemWrite is constant 0.

Test Plan:
- Reset then fetch_start=1, memory acks immediately with data 16'h2008 then 16'h0005 → IRWr1 pulse at cycle 1 with mem_addr=0, IRWr0 pulse at cycle 2 with mem_addr=2, instr_valid at cycle 3, pc=4 afterwards.
- Memory inserts 3 wait cycles per halfword → mem_req and mem_addr stay stable during the waits, one IRWr pulse per ack, instr_valid 8 cycles after start, no fault.
- pc_load=1 with pc_next_in=16'h0101 and fetch_start=1 in the same IDLE cycle → first mem_addr=16'h0100, second 16'h0102, final pc=16'h0104.
- pc at 16'hFFFC, fetch completes → second address 16'hFFFE, pc wraps to 16'h0000. From pc=16'hFFFE, second address is 16'h0000.
- No mem_ack for 15 cycles in REQ_HI → state FAULT, fetch_fault=1, mem_req=0. A later fetch_start is ignored. Reset clears the fault and pc returns to RESET_PC.
- Reset asserted in REQ_LO while mem_ack=1 → no IRWr0 pulse, all outputs at reset values next cycle. A stray mem_ack in IDLE produces no IRWr pulse.
